// File: rtl/cam_entry_mgr.sv
// cam_entry_mgr: serialises insert/delete commands onto an SRL CAM, allocating
// the lowest free address on insert and returning a status/address per command.
`default_nettype none

module cam_entry_mgr #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic                  full
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_DUPLICATE = 2'd1;
  localparam logic [1:0] ST_FULL      = 2'd2;
  localparam logic [1:0] ST_NOT_FOUND = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CHECK   = 3'd2,
    ISSUE   = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   key_reg;
  logic                    op_reg;
  logic [ENTRIES-1:0]      valid_map;
  logic [ADDR_WIDTH-1:0]   alloc_addr;
  logic                    accept;

  assign accept = req_valid & req_ready;
  assign full   = (used_count == (ADDR_WIDTH+1)'(ENTRIES));

  // Lowest clear bitmap position; scanning downward lets the smallest index win.
  always_comb begin
    alloc_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_map[i]) alloc_addr = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = CHECK;
      CHECK: begin
        if (!op_reg) state_nxt = (cam_match || full) ? RESP : ISSUE;
        else         state_nxt = cam_match ? ISSUE : RESP;
      end
      ISSUE:   state_nxt = WAIT_HI;
      WAIT_HI: if (cam_write_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!cam_write_busy) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_status      <= 2'd0;
      resp_addr        <= '0;
      cam_write_enable <= 1'b0;
      cam_write_delete <= 1'b0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_compare_data <= '0;
      key_reg          <= '0;
      op_reg           <= 1'b0;
      used_count       <= '0;
      valid_map        <= '0;
    end else begin
      // Ready is registered so it stays low through the CAM init after reset.
      req_ready        <= (state_nxt == IDLE) && !cam_write_busy;
      resp_valid       <= 1'b0;
      cam_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            key_reg          <= req_key;
            cam_compare_data <= req_key;
            op_reg           <= req_op;
          end
        end
        CHECK: begin
          if (!op_reg) begin
            if (cam_match) begin
              resp_valid  <= 1'b1;
              resp_status <= ST_DUPLICATE;
              resp_addr   <= cam_match_addr;
            end else if (full) begin
              resp_valid  <= 1'b1;
              resp_status <= ST_FULL;
              resp_addr   <= '0;
            end else begin
              cam_write_addr   <= alloc_addr;
              cam_write_data   <= key_reg;
              cam_write_delete <= 1'b0;
              cam_write_enable <= 1'b1;
            end
          end else begin
            if (cam_match) begin
              cam_write_addr   <= cam_match_addr;
              cam_write_delete <= 1'b1;
              cam_write_enable <= 1'b1;
            end else begin
              resp_valid  <= 1'b1;
              resp_status <= ST_NOT_FOUND;
              resp_addr   <= '0;
            end
          end
        end
        ISSUE: begin
          if (cam_write_delete) begin
            valid_map[cam_write_addr] <= 1'b0;
            used_count                <= used_count - 1'b1;
          end else begin
            valid_map[cam_write_addr] <= 1'b1;
            used_count                <= used_count + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!cam_write_busy) begin
            resp_valid  <= 1'b1;
            resp_status <= ST_OK;
            resp_addr   <= cam_write_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_entry_mgr.sv
// Scoreboard bench for cam_entry_mgr with a behavioural SRL CAM (16-cycle writes/init).
`default_nettype none

module tb_cam_entry_mgr;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int N  = 1 << AW;
  localparam int WR_CYCLES = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [DW-1:0] req_key = '0;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_addr;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;
  logic [AW:0]   used_count;
  logic          full;

  cam_entry_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_addr(resp_addr),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .used_count(used_count), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CAM: registered match, busy for WR_CYCLES after a write or reset.
  logic [DW-1:0] cam_key [N];
  logic [N-1:0]  cam_vld;
  int            busy_cnt;
  assign cam_write_busy = (busy_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vld        <= '0;
      busy_cnt       <= WR_CYCLES;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      logic          m;
      logic [AW-1:0] ma;
      m  = 1'b0;
      ma = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
          m  = 1'b1;
          ma = AW'(i);
        end
      end
      cam_match      <= m;
      cam_match_addr <= ma;
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (cam_write_enable) begin
        busy_cnt <= WR_CYCLES;
        if (cam_write_delete) cam_vld[cam_write_addr] <= 1'b0;
        else begin
          cam_vld[cam_write_addr] <= 1'b1;
          cam_key[cam_write_addr] <= cam_write_data;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference table: which key lives at which address.
  logic [DW-1:0] mkey [N];
  bit            mvld [N];

  typedef struct {
    int  st;
    int  addr;
    int  used;
    int  lat;
    bit  wr;
    bit  del;
    int  acc;
    int  wr_before;
  } item_t;

  item_t sb[$];
  int    wr_cnt = 0;
  int    last_waddr = 0;
  bit    last_wdel = 0;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (mvld[i]) c++;
    return c;
  endfunction

  function automatic int model_find(input logic [DW-1:0] k);
    for (int i = 0; i < N; i++) if (mvld[i] && mkey[i] == k) return i;
    return -1;
  endfunction

  function automatic item_t model_apply(input bit op, input logic [DW-1:0] k, input int acc);
    item_t it;
    int    f;
    f = model_find(k);
    it.acc = acc; it.wr_before = wr_cnt; it.wr = 0; it.del = 0; it.addr = 0; it.lat = 3;
    if (!op) begin
      if (f >= 0) begin
        it.st = 1; it.addr = f;
      end else if (model_count() == N) begin
        it.st = 2;
      end else begin
        for (int i = N - 1; i >= 0; i--) if (!mvld[i]) f = i;
        mvld[f] = 1; mkey[f] = k;
        it.st = 0; it.addr = f; it.wr = 1; it.lat = 3 + 1 + WR_CYCLES + 1;
      end
    end else begin
      if (f >= 0) begin
        mvld[f] = 0;
        it.st = 0; it.addr = f; it.wr = 1; it.del = 1; it.lat = 3 + 1 + WR_CYCLES + 1;
      end else begin
        it.st = 3;
      end
    end
    it.used = model_count();
    return it;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (cam_write_enable) begin
        wr_cnt++;
        last_waddr = int'(cam_write_addr);
        last_wdel  = cam_write_delete;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          item_t it;
          it = sb.pop_front();
          chk("resp_status", 64'(resp_status), 64'(it.st));
          chk("resp_addr", 64'(resp_addr), 64'(it.addr));
          chk("resp_latency", 64'(cyc - it.acc), 64'(it.lat));
          chk("used_count", 64'(used_count), 64'(it.used));
          chk("full", 64'(full), 64'(it.used == N));
          chk("write_pulses", 64'(wr_cnt - it.wr_before), 64'(it.wr));
          if (it.wr) begin
            chk("write_addr", 64'(last_waddr), 64'(it.addr));
            chk("write_delete", 64'(last_wdel), 64'(it.del));
          end
        end
      end
    end
  end

  int last_acc = 0;

  task automatic do_cmd(input bit op, input logic [DW-1:0] k);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_key = k;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    sb.push_back(model_apply(op, k, cyc));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic release_and_init();
    int t = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_during_init", 64'(req_ready), 64'd0);
    chk("used_after_reset", 64'(used_count), 64'd0);
    while (cam_write_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("init_busy_fell", 64'(cam_write_busy), 64'd0);
    chk("ready_same_cycle_busy_falls", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_busy_fall", 64'(req_ready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mvld[i] = 0;
    repeat (3) @(negedge clk);
    release_and_init();

    do_cmd(1'b0, 64'h0123_4567_89AB_CDEF);
    do_cmd(1'b0, 64'h0123_4567_89AB_CDEF);
    do_cmd(1'b1, 64'h0123_4567_89AB_CDEF);
    do_cmd(1'b1, 64'hDEAD);
    drain();

    for (int k = 1; k <= 33; k++) do_cmd(1'b0, 64'(k));
    do_cmd(1'b1, 64'd6);
    do_cmd(1'b0, 64'd99);
    drain();

    for (int n = 0; n < 150; n++) begin
      do_cmd(1'($urandom_range(0, 1)), 64'($urandom_range(1, 40)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    // Reset while the CAM write is in progress: the pending response must vanish.
    do_cmd(1'b0, 64'h5555_AAAA);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    for (int i = 0; i < N; i++) mvld[i] = 0;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    chk("rst_resp_addr", 64'(resp_addr), 64'd0);
    chk("rst_wr_enable", 64'(cam_write_enable), 64'd0);
    chk("rst_wr_delete", 64'(cam_write_delete), 64'd0);
    chk("rst_wr_addr", 64'(cam_write_addr), 64'd0);
    chk("rst_wr_data", cam_write_data, 64'd0);
    chk("rst_compare", cam_compare_data, 64'd0);
    chk("rst_used", 64'(used_count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    repeat (3) @(negedge clk);
    release_and_init();
    repeat (30) @(negedge clk);
    do_cmd(1'b1, 64'h5555_AAAA);
    do_cmd(1'b0, 64'h7777);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
